// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl
// Round sequencer for the whack-a-mole game. Each round picks a pseudo-random
// pattern of one or two moles and opens a timed hit window. Presses on lit
// moles are latched until the window closes, either because the timer expires
// or because every lit mole has been hit. The block then strobes score_valid
// for one cycle so the score counter can read a stable pattern/hit pair.
// After ROUNDS rounds it parks in DONE until the next start pulse.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   start       single-cycle start pulse, already debounced
//   buttons     debounced button levels, 1 = pressed
//   led_moles   current mole pattern
//   hit_reg     moles hit in the current round
//   score_valid one-cycle strobe, led_moles/hit_reg are final for this round
//   round_num   rounds completed, 0..ROUNDS
//   busy        high in any state other than IDLE and DONE
//   game_over   high in DONE
module mole_round_ctrl #(
  parameter int          N_MOLES       = 18,
  parameter int          ACTIVE_CYCLES = 50000000,
  parameter int          GAP_CYCLES    = 12500000,
  parameter int          ROUNDS        = 30,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_MOLES-1:0] buttons,
  output logic [N_MOLES-1:0] led_moles,
  output logic [N_MOLES-1:0] hit_reg,
  output logic               score_valid,
  output logic [5:0]         round_num,
  output logic               busy,
  output logic               game_over
);

  localparam int MAX_CYCLES = (ACTIVE_CYCLES > GAP_CYCLES) ? ACTIVE_CYCLES : GAP_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES);
  localparam int IW         = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;
  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    ACTIVE,
    SCORE,
    GAP,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [TW-1:0]      timer;
  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic [N_MOLES-1:0] hit_next;
  logic [5:0]         round_inc;

  // Mole pattern: one mole from the low five LFSR bits, plus a second one from
  // bits 9:5 when bit 10 is set. If both land on the same index the pattern
  // simply has one mole, so it is never empty.
  function automatic logic [N_MOLES-1:0] pattern(input logic [15:0] l);
    logic [N_MOLES-1:0] p;
    logic [IW-1:0]      a;
    logic [IW-1:0]      b;
    a = IW'(int'(l[4:0]) % N_MOLES);
    b = IW'(int'(l[9:5]) % N_MOLES);
    p = '0;
    p[a] = 1'b1;
    if (l[10]) p[b] = 1'b1;
    return p;
  endfunction

  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  // Presses on unlit positions are masked off; earlier hits stay latched.
  assign hit_next  = hit_reg | (buttons & led_moles);
  assign round_inc = round_num + 6'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. The early-clear test uses the hit vector that is about
  // to be latched, so the round ends the cycle after the completing press.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SPAWN;
      SPAWN:   state_next = ACTIVE;
      ACTIVE:  if (timer == '0 || hit_next == led_moles) state_next = SCORE;
      SCORE:   state_next = (round_inc == 6'(ROUNDS)) ? DONE : GAP;
      GAP:     if (timer == '0) state_next = SPAWN;
      DONE:    if (start) state_next = SPAWN;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs. The status flags are derived from the
  // next state so they line up exactly with the state register. Pattern and
  // hits are cleared on the way out of SCORE, keeping them stable while
  // score_valid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr        <= SEED;
      timer       <= '0;
      led_moles   <= '0;
      hit_reg     <= '0;
      score_valid <= 1'b0;
      round_num   <= '0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      lfsr        <= {lfsr[14:0], lfsr_fb};
      score_valid <= (state_next == SCORE);
      busy        <= (state_next != IDLE) && (state_next != DONE);
      game_over   <= (state_next == DONE);
      case (state)
        SPAWN: begin
          led_moles <= pattern(lfsr);
          hit_reg   <= '0;
          timer     <= TW'(ACTIVE_CYCLES - 1);
        end
        ACTIVE: begin
          hit_reg <= hit_next;
          if (timer != '0) timer <= timer - 1'b1;
        end
        SCORE: begin
          round_num <= round_inc;
          led_moles <= '0;
          hit_reg   <= '0;
          timer     <= TW'(GAP_CYCLES - 1);
        end
        GAP: begin
          if (timer != '0) timer <= timer - 1'b1;
        end
        DONE: begin
          if (start) round_num <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb_mole_round_ctrl
// Self-checking bench for mole_round_ctrl. Each cycle it drives reset, start
// and buttons, advances a behavioural model of the game (phases measured by an
// up-counting age, LFSR and pattern computed arithmetically), and compares
// every output against the model on the falling edge.
module tb_mole_round_ctrl;

  localparam int N    = 18;
  localparam int ACT  = 8;
  localparam int GAPC = 3;
  localparam int RND  = 3;

  localparam int PH_IDLE   = 0;
  localparam int PH_SPAWN  = 1;
  localparam int PH_ACTIVE = 2;
  localparam int PH_SCORE  = 3;
  localparam int PH_GAP    = 4;
  localparam int PH_DONE   = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] buttons;
  logic [N-1:0] led_moles;
  logic [N-1:0] hit_reg;
  logic         score_valid;
  logic [5:0]   round_num;
  logic         busy;
  logic         game_over;

  int errors = 0;
  int checks = 0;

  // Model state.
  int           m_phase  = PH_IDLE;
  int           m_age    = 0;
  int           m_rounds = 0;
  int           m_lfsr   = 'hACE1;
  logic [N-1:0] m_mole   = '0;
  logic [N-1:0] m_hits   = '0;

  mole_round_ctrl #(
    .N_MOLES      (N),
    .ACTIVE_CYCLES(ACT),
    .GAP_CYCLES   (GAPC),
    .ROUNDS       (RND),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .buttons    (buttons),
    .led_moles  (led_moles),
    .hit_reg    (hit_reg),
    .score_valid(score_valid),
    .round_num  (round_num),
    .busy       (busy),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  function automatic int lfsrNext(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l * 2) + fb) % 65536;
  endfunction

  function automatic logic [N-1:0] patternOf(input int l);
    int a;
    int b;
    logic [N-1:0] r;
    a = (l % 32) % N;
    b = ((l / 32) % 32) % N;
    r = N'(1) << a;
    if (((l / 1024) % 2) == 1) r = r | (N'(1) << b);
    return r;
  endfunction

  // One clock of the game rules, applied with the inputs seen at that edge.
  task automatic modelStep(input logic r, input logic s, input logic [N-1:0] b);
    int cur;
    if (r) begin
      m_phase  = PH_IDLE;
      m_age    = 0;
      m_rounds = 0;
      m_lfsr   = 'hACE1;
      m_mole   = '0;
      m_hits   = '0;
      return;
    end
    cur    = m_lfsr;
    m_lfsr = lfsrNext(m_lfsr);
    case (m_phase)
      PH_IDLE: if (s) m_phase = PH_SPAWN;
      PH_SPAWN: begin
        m_mole  = patternOf(cur);
        m_hits  = '0;
        m_age   = 0;
        m_phase = PH_ACTIVE;
      end
      PH_ACTIVE: begin
        m_hits = m_hits | (b & m_mole);
        if (m_age == ACT - 1 || m_hits == m_mole) m_phase = PH_SCORE;
        else m_age++;
      end
      PH_SCORE: begin
        m_rounds++;
        m_mole = '0;
        m_hits = '0;
        m_age  = 0;
        m_phase = (m_rounds == RND) ? PH_DONE : PH_GAP;
      end
      PH_GAP: begin
        if (m_age == GAPC - 1) m_phase = PH_SPAWN;
        else m_age++;
      end
      PH_DONE: begin
        if (s) begin
          m_phase  = PH_SPAWN;
          m_rounds = 0;
        end
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic compareAll();
    checkOutput("led_moles",   32'(led_moles),   32'(m_mole));
    checkOutput("hit_reg",     32'(hit_reg),     32'(m_hits));
    checkOutput("score_valid", 32'(score_valid), (m_phase == PH_SCORE) ? 32'd1 : 32'd0);
    checkOutput("round_num",   32'(round_num),   32'(m_rounds));
    checkOutput("busy",        32'(busy),        (m_phase != PH_IDLE && m_phase != PH_DONE) ? 32'd1 : 32'd0);
    checkOutput("game_over",   32'(game_over),   (m_phase == PH_DONE) ? 32'd1 : 32'd0);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare.
  task automatic applyStimulus(input logic r, input logic s, input logic [N-1:0] b);
    reset   = r;
    start   = s;
    buttons = b;
    @(posedge clk);
    modelStep(r, s, b);
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    logic [N-1:0] b;
    logic         s;
    logic         r;
    int           sel;

    // Cold reset and a quiet idle period.
    repeat (2) applyStimulus(1'b1, 1'b0, '0);
    repeat (3) applyStimulus(1'b0, 1'b0, '0);

    // Full game with no presses: every round runs to timer expiry.
    applyStimulus(1'b0, 1'b1, '0);
    repeat (60) applyStimulus(1'b0, 1'b0, '0);

    // Reset a few cycles into the hit window, then restart.
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, '0);
    repeat (4) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, '0);
    repeat (20) applyStimulus(1'b0, 1'b0, '0);

    // Directed hits: full clear on the third window cycle, one-cycle pulse.
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, '0);
    for (int i = 0; i < 60; i++) begin
      b = (m_phase == PH_ACTIVE && m_age == 2) ? m_mole : '0;
      applyStimulus(1'b0, 1'b0, b);
    end

    // Partial hits: lowest lit mole plus unlit noise, window must run out.
    applyStimulus(1'b0, 1'b1, '0);
    for (int i = 0; i < 60; i++) begin
      b = (m_mole & (~m_mole + 1'b1)) | (N'($urandom) & ~m_mole);
      if (m_mole == (m_mole & (~m_mole + 1'b1))) b = N'($urandom) & ~m_mole;
      applyStimulus(1'b0, 1'b0, b);
    end

    // Randomized play with stray start pulses and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 399) == 0);
      s   = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       b = '0;
        1:       b = N'($urandom) & N'($urandom) & N'($urandom);
        2:       b = m_mole & N'($urandom);
        default: b = N'($urandom);
      endcase
      applyStimulus(r, s, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
